// File: rtl/ssd_mux_decoder_if.sv
// Bus between a seven-segment display driver and the loopback decoder.
// master drives the display pins and ready; slave is the decoder.
interface ssd_mux_decoder_if;
    logic [6:0] ssd_anode;
    logic       ssd_cathode;
    logic [7:0] value;
    logic       value_valid;
    logic       value_ready;
    logic       decode_err;
    logic       overrun;
    logic       stale;

    modport master (
        output ssd_anode, ssd_cathode, value_ready,
        input  value, value_valid, decode_err, overrun, stale
    );
    modport slave (
        input  ssd_anode, ssd_cathode, value_ready,
        output value, value_valid, decode_err, overrun, stale
    );
endinterface

// File: rtl/ssd_mux_decoder.sv
// Decodes a 2-digit multiplexed seven-segment bus back into a hex byte.
// Each digit is captured once after its pattern settles; frames go out on valid/ready.
module ssd_mux_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic CLK,
    input logic RST,
    ssd_mux_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {SETTLE, CAPTURE, HOLD} state_t;

    // {legal, nibble}
    function automatic logic [4:0] glyph_decode(input logic [6:0] pat);
        case (pat)
            7'h3F: glyph_decode = 5'h10;
            7'h06: glyph_decode = 5'h11;
            7'h5B: glyph_decode = 5'h12;
            7'h4F: glyph_decode = 5'h13;
            7'h66: glyph_decode = 5'h14;
            7'h6D: glyph_decode = 5'h15;
            7'h7D: glyph_decode = 5'h16;
            7'h07: glyph_decode = 5'h17;
            7'h7F: glyph_decode = 5'h18;
            7'h6F: glyph_decode = 5'h19;
            7'h77: glyph_decode = 5'h1A;
            7'h7C: glyph_decode = 5'h1B;
            7'h39: glyph_decode = 5'h1C;
            7'h5E: glyph_decode = 5'h1D;
            7'h79: glyph_decode = 5'h1E;
            7'h71: glyph_decode = 5'h1F;
            default: glyph_decode = 5'h00;
        endcase
    endfunction

    state_t        state;
    logic [7:0]    s, s_prev;
    logic [CW-1:0] settle_cnt;
    logic [TW-1:0] edge_cnt;
    logic [3:0]    lo_slot, hi_slot;
    logic          have_lo, have_hi;

    logic       change, cath_edge, frame_done, accept, capture_ok, capture_bad;
    logic [4:0] dec;

    always_comb begin
        change      = (s != s_prev);
        cath_edge   = s[7] ^ s_prev[7];
        dec         = glyph_decode(s[6:0]);
        frame_done  = have_lo & have_hi;
        accept      = bus.value_valid & bus.value_ready;
        // a pattern that moves during the capture cycle is abandoned, not decoded
        capture_ok  = (state == CAPTURE) && !change && dec[4];
        capture_bad = (state == CAPTURE) && !change && !dec[4];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= SETTLE;
            s               <= '0;
            s_prev          <= '0;
            settle_cnt      <= '0;
            edge_cnt        <= '0;
            lo_slot         <= '0;
            hi_slot         <= '0;
            have_lo         <= 1'b0;
            have_hi         <= 1'b0;
            bus.value       <= '0;
            bus.value_valid <= 1'b0;
            bus.decode_err  <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.stale       <= 1'b0;
        end else begin
            s      <= {bus.ssd_cathode, bus.ssd_anode};
            s_prev <= s;

            if (change)
                settle_cnt <= '0;
            else if (settle_cnt != CW'(STABLE_CYCLES))
                settle_cnt <= settle_cnt + 1'b1;

            case (state)
                SETTLE:  if (!change && settle_cnt == CW'(STABLE_CYCLES - 1)) state <= CAPTURE;
                CAPTURE: state <= change ? SETTLE : HOLD;
                HOLD:    if (change) state <= SETTLE;
                default: state <= SETTLE;
            endcase

            bus.decode_err <= capture_bad;
            bus.overrun    <= 1'b0;

            if (accept)
                bus.value_valid <= 1'b0;

            if (frame_done) begin
                have_lo <= 1'b0;
                have_hi <= 1'b0;
                if (!bus.value_valid || accept) begin
                    bus.value       <= {hi_slot, lo_slot};
                    bus.value_valid <= 1'b1;
                end else begin
                    bus.overrun <= 1'b1;
                end
            end

            // a bus that stops multiplexing cannot finish a frame; drop partial digits
            if (cath_edge) begin
                edge_cnt  <= '0;
                bus.stale <= 1'b0;
            end else if (edge_cnt != TW'(TIMEOUT_CYCLES)) begin
                edge_cnt <= edge_cnt + 1'b1;
                if (edge_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bus.stale <= 1'b1;
                    have_lo   <= 1'b0;
                    have_hi   <= 1'b0;
                end
            end

            if (capture_ok) begin
                if (s[7]) begin
                    hi_slot <= dec[3:0];
                    have_hi <= 1'b1;
                end else begin
                    lo_slot <= dec[3:0];
                    have_lo <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ssd_mux_decoder.sv
// Self-checking bench: phase-level model of digit capture, frames and handshake.
module tb_ssd_mux_decoder;
    logic CLK, RST;
    ssd_mux_decoder_if bus ();

    ssd_mux_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int total = 0;
    int bad   = 0;

    // monitor results
    logic [7:0] got [$];
    int n_err, n_ovr, n_valid, n_unstable;
    logic       prev_hold;
    logic [7:0] prev_val;

    // model state
    logic [7:0] exp_q [$];
    int exp_err, exp_ovr, m_same;
    logic [3:0] m_slot [2];
    logic [1:0] m_have;
    logic m_held, m_lastc;

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.value_valid && bus.value_ready) got.push_back(bus.value);
            if (bus.value_valid) n_valid++;
            if (bus.decode_err) n_err++;
            if (bus.overrun) n_ovr++;
            if (prev_hold && bus.value !== prev_val) n_unstable++;
            prev_hold = bus.value_valid && !bus.value_ready;
            prev_val  = bus.value;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        bus.ssd_anode = '0;
        bus.ssd_cathode = 1'b0;
        idle(2);
        RST = 1'b0;
        got.delete(); exp_q.delete();
        n_err = 0; n_ovr = 0; n_valid = 0; n_unstable = 0; prev_hold = 1'b0; prev_val = '0;
        exp_err = 0; exp_ovr = 0; m_same = 0; m_have = '0; m_held = 1'b0; m_lastc = 1'b0;
        m_slot[0] = '0; m_slot[1] = '0;
    endtask

    // A run of constant pins lasting len cycles is captured iff it lasts >= 6 cycles.
    task automatic model_run(input bit c, input bit [6:0] p, input int len);
        bit found = 0;
        logic [3:0] nib = '0;
        if (c != m_lastc) m_same = 0;
        m_lastc = c;
        m_same += len;
        if (len >= 6) begin
            for (int i = 0; i < 16; i++) if (glyph[i] == p) begin found = 1; nib = 4'(i); end
            if (!found) exp_err++;
            else begin
                m_slot[c] = nib;
                m_have[c] = 1'b1;
                if (m_have == 2'b11) begin
                    m_have = '0;
                    if (!m_held) begin
                        exp_q.push_back({m_slot[1], m_slot[0]});
                        m_held = !bus.value_ready;
                    end else exp_ovr++;
                end
            end
        end
        if (m_same > 1030) m_have = '0;
    endtask

    task automatic drive_run(input bit c, input bit [6:0] p, input int len);
        model_run(c, p, len);
        bus.ssd_cathode = c;
        bus.ssd_anode = p;
        idle(len);
    endtask

    task automatic test_reset();
        bus.value_ready = 1'b0;
        reset_dut();
        total += 5;
        if (bus.value !== 8'h00) begin bad++; $display("FAIL rst_value got=%h want=00", bus.value); end
        if (bus.value_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.value_valid); end
        if (bus.decode_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus.decode_err); end
        if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr got=%b want=0", bus.overrun); end
        if (bus.stale !== 1'b0) begin bad++; $display("FAIL rst_stale got=%b want=0", bus.stale); end
    endtask

    task automatic test_basic();
        reset_dut();
        bus.value_ready = 1'b1;
        drive_run(0, 7'h6D, 10);
        drive_run(1, 7'h77, 10);
        idle(3);
        total += 4;
        if (got.size() !== 1 || exp_q.size() !== 1) begin bad++; $display("FAIL basic_count got=%0d want=%0d", got.size(), exp_q.size()); end
        else if (got[0] !== 8'hA5 || exp_q[0] !== 8'hA5) begin bad++; $display("FAIL basic_value got=%h want=A5", got[0]); end
        if (n_valid !== 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d want=1", n_valid); end
        if (n_err !== exp_err) begin bad++; $display("FAIL basic_err got=%0d want=%0d", n_err, exp_err); end
        if (n_ovr !== 0) begin bad++; $display("FAIL basic_ovr got=%0d want=0", n_ovr); end
    endtask

    task automatic test_glitch();
        reset_dut();
        bus.value_ready = 1'b1;
        drive_run(0, 7'h6D, 6);
        drive_run(0, 7'h7F, 2);
        drive_run(0, 7'h6D, 3);
        drive_run(1, 7'h77, 10);
        idle(3);
        total += 2;
        if (got.size() !== 1) begin bad++; $display("FAIL glitch_count got=%0d want=1", got.size()); end
        else if (got[0] !== exp_q[0]) begin bad++; $display("FAIL glitch_value got=%h want=%h", got[0], exp_q[0]); end
        if (n_err !== exp_err) begin bad++; $display("FAIL glitch_err got=%0d want=%0d", n_err, exp_err); end
    endtask

    task automatic test_bad_glyph();
        reset_dut();
        bus.value_ready = 1'b1;
        drive_run(0, 7'h6D, 10);
        drive_run(1, 7'h00, 10);
        idle(3);
        total += 2;
        if (n_err !== 1 || exp_err !== 1) begin bad++; $display("FAIL badglyph_err got=%0d want=1", n_err); end
        if (n_valid !== 0) begin bad++; $display("FAIL badglyph_valid got=%0d want=0", n_valid); end
    endtask

    task automatic test_overrun();
        reset_dut();
        bus.value_ready = 1'b0;
        drive_run(0, 7'h5B, 10);
        drive_run(1, 7'h06, 10);
        drive_run(0, 7'h4F, 10);
        drive_run(1, 7'h66, 10);
        idle(3);
        total += 3;
        if (bus.value !== 8'h12) begin bad++; $display("FAIL ovr_held_value got=%h want=12", bus.value); end
        if (bus.value_valid !== 1'b1) begin bad++; $display("FAIL ovr_held_valid got=%b want=1", bus.value_valid); end
        if (n_ovr !== exp_ovr || n_ovr !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=%0d", n_ovr, exp_ovr); end
        bus.value_ready = 1'b1;
        m_held = 1'b0;
        idle(3);
        total += 1;
        if (bus.value_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept_valid got=%b want=0", bus.value_valid); end
        drive_run(0, 7'h6D, 10);
        drive_run(1, 7'h7D, 10);
        idle(3);
        total += 2;
        if (got.size() !== exp_q.size()) begin bad++; $display("FAIL ovr_count got=%0d want=%0d", got.size(), exp_q.size()); end
        else foreach (exp_q[i]) if (got[i] !== exp_q[i]) begin bad++; $display("FAIL ovr_value[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        if (n_unstable !== 0) begin bad++; $display("FAIL ovr_stable got=%0d want=0", n_unstable); end
    endtask

    task automatic test_stale();
        reset_dut();
        bus.value_ready = 1'b1;
        drive_run(0, 7'h4F, 10);
        drive_run(1, 7'h77, 10);
        model_run(0, 7'h6D, 1100);
        bus.ssd_cathode = 1'b0;
        bus.ssd_anode = 7'h6D;
        idle(1000);
        total += 1;
        if (bus.stale !== 1'b0) begin bad++; $display("FAIL stale_early got=%b want=0", bus.stale); end
        idle(100);
        total += 1;
        if (bus.stale !== 1'b1) begin bad++; $display("FAIL stale_set got=%b want=1", bus.stale); end
        drive_run(1, 7'h77, 10);
        total += 1;
        if (bus.stale !== 1'b0) begin bad++; $display("FAIL stale_clear got=%b want=0", bus.stale); end
        drive_run(0, 7'h5B, 10);
        idle(3);
        total += 1;
        if (got.size() !== 2) begin bad++; $display("FAIL stale_count got=%0d want=2", got.size()); end
        else foreach (exp_q[i]) begin
            total++;
            if (got[i] !== exp_q[i]) begin bad++; $display("FAIL stale_value[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        bus.value_ready = 1'b1;
        drive_run(0, 7'h6D, 10);
        reset_dut();
        total += 1;
        if (bus.value_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus.value_valid); end
        drive_run(1, 7'h3F, 10);
        drive_run(0, 7'h71, 10);
        idle(3);
        total += 1;
        if (got.size() !== 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", got.size()); end
        else if (got[0] !== 8'h0F || exp_q[0] !== 8'h0F) begin bad++; $display("FAIL midrst_value got=%h want=0F", got[0]); end
    endtask

    task automatic test_random();
        bit c;
        bit [6:0] p;
        bit [7:0] prev;
        int len;
        reset_dut();
        bus.value_ready = 1'b1;
        prev = '0;
        for (int k = 0; k < 50; k++) begin
            do begin
                c = 1'($urandom_range(0, 1));
                p = ($urandom_range(0, 3) != 0) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
            end while ({c, p} == prev || {c, p} == 8'h00);
            prev = {c, p};
            len = (k == 49) ? 20 : int'($urandom_range(1, 12));
            drive_run(c, p, len);
        end
        idle(3);
        total += 3;
        if (got.size() !== exp_q.size()) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", got.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            total++;
            if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_value[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
        if (n_err !== exp_err) begin bad++; $display("FAIL rnd_err got=%0d want=%0d", n_err, exp_err); end
        if (n_ovr !== 0) begin bad++; $display("FAIL rnd_ovr got=%0d want=0", n_ovr); end
    endtask

    initial begin
        RST = 1'b1;
        bus.ssd_anode = '0;
        bus.ssd_cathode = 1'b0;
        bus.value_ready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_bad_glyph();
        test_overrun();
        test_stale();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
